// File: rtl/fetch_hazard_controller.sv
// Fetch-side pipeline control: load-use stalls, taken-branch redirect with flush window,
// imem wait states with sticky timeout error, and saturating stall/redirect counters.
module fetch_hazard_controller #(
  parameter int FLUSH_CYCLES = 1,
  parameter int TIMEOUT      = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic             idUsesRt,
  input  logic             exMemRead,
  input  logic [4:0]       exRt,
  input  logic             exBranchTaken,
  input  logic [31:0]      exBranchTarget,
  input  logic             imemReady,
  output logic             stall,
  output logic             branchResult,
  output logic [31:0]      branchAddrs,
  output logic             flushIfId,
  output logic             bubbleIdEx,
  output logic             fetchError,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] redirectCount
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0]       WAIT_LIMIT = 8'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state_q, state_d, state_eff;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
  logic             hazard;

  assign hazard = exMemRead && (exRt != 5'd0) &&
                  ((exRt == idRs) || (idUsesRt && (exRt == idRt)));

  // Outputs during the reset cycle behave as if already back in RUN.
  assign state_eff = reset ? ST_RUN : state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    fetch_err_d = fetch_err_q;
    case (state_q)
      ST_RUN, ST_WAIT: begin
        if (exBranchTaken) begin
          wait_cnt_d = '0;
          if (FLUSH_CYCLES > 1) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_LOAD;
          end else begin
            state_d     = ST_RUN;
          end
        end else if (!imemReady) begin
          state_d = ST_WAIT;
          if (state_q == ST_RUN) begin
            wait_cnt_d = 8'd1;
          end else if (wait_cnt_q != WAIT_LIMIT) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
          if (wait_cnt_d == WAIT_LIMIT) begin
            fetch_err_d = 1'b1;
          end
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      ST_FLUSH: begin
        // EX holds a bubble here, so a taken branch or imem status cannot matter.
        if (flush_cnt_q <= 4'd1) begin
          state_d     = ST_RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = '0;
        wait_cnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    stall        = 1'b0;
    branchResult = 1'b0;
    flushIfId    = 1'b0;
    bubbleIdEx   = 1'b0;
    case (state_eff)
      ST_FLUSH: begin
        flushIfId  = 1'b1;
        bubbleIdEx = 1'b1;
      end
      default: begin
        // WAIT with imemReady=1 resolves exactly like RUN, including the hazard check.
        if (exBranchTaken) begin
          branchResult = 1'b1;
          flushIfId    = 1'b1;
          bubbleIdEx   = 1'b1;
        end else if (!imemReady) begin
          stall = 1'b1;
        end else if (hazard) begin
          stall      = 1'b1;
          bubbleIdEx = 1'b1;
        end
      end
    endcase
  end

  assign branchAddrs = branchResult ? exBranchTarget : 32'd0;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (branchResult && (redir_cnt_q != CNT_MAX)) begin
      redir_cnt_d = redir_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_err_q <= 1'b0;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      fetch_err_q <= fetch_err_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign fetchError    = fetch_err_q;
  assign stallCycles   = stall_cnt_q;
  assign redirectCount = redir_cnt_q;

endmodule

// File: tb/tb_fetch_hazard_controller.sv
// Bench for fetch_hazard_controller: two instances (A: flush 3/timeout 16/16-bit counters,
// B: flush 1/timeout 2/3-bit counters) checked each cycle against a behavioural model.
module tb_fetch_hazard_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  idRs, idRt, exRt;
  logic        idUsesRt, exMemRead, exBranchTaken, imemReady;
  logic [31:0] exBranchTarget;

  logic        a_stall, a_br, a_flush, a_bub, a_err;
  logic [31:0] a_addr;
  logic [15:0] a_sc, a_rc;
  logic        b_stall, b_br, b_flush, b_bub, b_err;
  logic [31:0] b_addr;
  logic [2:0]  b_sc, b_rc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_hazard_controller #(.FLUSH_CYCLES(3), .TIMEOUT(16), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exMemRead(exMemRead), .exRt(exRt), .exBranchTaken(exBranchTaken),
    .exBranchTarget(exBranchTarget), .imemReady(imemReady),
    .stall(a_stall), .branchResult(a_br), .branchAddrs(a_addr), .flushIfId(a_flush),
    .bubbleIdEx(a_bub), .fetchError(a_err), .stallCycles(a_sc), .redirectCount(a_rc)
  );

  fetch_hazard_controller #(.FLUSH_CYCLES(1), .TIMEOUT(2), .CNT_W(3)) u_b (
    .clk(clk), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exMemRead(exMemRead), .exRt(exRt), .exBranchTaken(exBranchTaken),
    .exBranchTarget(exBranchTarget), .imemReady(imemReady),
    .stall(b_stall), .branchResult(b_br), .branchAddrs(b_addr), .flushIfId(b_flush),
    .bubbleIdEx(b_bub), .fetchError(b_err), .stallCycles(b_sc), .redirectCount(b_rc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining forced-flush cycles, length of the current imem stall run,
  // sticky error and the two counters, one set per instance.
  int FC[2] = '{3, 1};
  int TO[2] = '{16, 2};
  int CM[2] = '{65535, 7};
  int fl[2], wr[2], sc[2], rc[2];
  bit er[2];
  bit mvalid = 1'b0;

  function automatic bit hz();
    return exMemRead && exRt != 0 && (exRt == idRs || (idUsesRt && exRt == idRt));
  endfunction

  // {stall, branchResult, flushIfId, bubbleIdEx} the instance must show this cycle
  function automatic logic [3:0] exp_ctl(input int k);
    logic st, br, fo, bu;
    if (!reset && fl[k] > 0) return 4'b0011;
    br = exBranchTaken;
    st = !br && (!imemReady || hz());
    bu = br || (imemReady && hz());
    fo = br;
    return {st, br, fo, bu};
  endfunction

  task automatic cmp_inst(input int k, input logic st, input logic br, input logic fo,
                          input logic bu, input logic e, input logic [31:0] ad,
                          input logic [31:0] s, input logic [31:0] r);
    logic [3:0] c;
    c = exp_ctl(k);
    chk($sformatf("i%0d stall", k), {31'd0, st}, {31'd0, c[3]});
    chk($sformatf("i%0d branchResult", k), {31'd0, br}, {31'd0, c[2]});
    chk($sformatf("i%0d flushIfId", k), {31'd0, fo}, {31'd0, c[1]});
    chk($sformatf("i%0d bubbleIdEx", k), {31'd0, bu}, {31'd0, c[0]});
    chk($sformatf("i%0d branchAddrs", k), ad, c[2] ? exBranchTarget : 32'd0);
    chk($sformatf("i%0d fetchError", k), {31'd0, e}, {31'd0, er[k]});
    chk($sformatf("i%0d stallCycles", k), s, sc[k]);
    chk($sformatf("i%0d redirectCount", k), r, rc[k]);
  endtask

  task automatic model_step(input int k);
    logic [3:0] c;
    if (reset) begin
      fl[k] = 0; wr[k] = 0; er[k] = 0; sc[k] = 0; rc[k] = 0;
    end else begin
      c = exp_ctl(k);
      if (c[3] && sc[k] < CM[k]) sc[k]++;
      if (c[2] && rc[k] < CM[k]) rc[k]++;
      if (fl[k] > 0) fl[k]--;
      else if (exBranchTaken) begin fl[k] = FC[k] - 1; wr[k] = 0; end
      else if (!imemReady) begin wr[k]++; if (wr[k] >= TO[k]) er[k] = 1; end
      else wr[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      cmp_inst(0, a_stall, a_br, a_flush, a_bub, a_err, a_addr, {16'd0, a_sc}, {16'd0, a_rc});
      cmp_inst(1, b_stall, b_br, b_flush, b_bub, b_err, b_addr, {29'd0, b_sc}, {29'd0, b_rc});
    end
    model_step(0);
    model_step(1);
    if (reset) mvalid = 1'b1;
  end

  task automatic quiet();
    idRs = 5'd1; idRt = 5'd2; idUsesRt = 1'b0; exMemRead = 1'b0; exRt = 5'd0;
    exBranchTaken = 1'b0; exBranchTarget = 32'd0; imemReady = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    quiet();
    reset = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("reset stall", {31'd0, a_stall}, 32'd0);
    chk("reset flush", {31'd0, a_flush}, 32'd0);
    chk("reset stallCycles", {16'd0, a_sc}, 32'd0);
    chk("reset redirectCount", {16'd0, a_rc}, 32'd0);
    chk("reset fetchError", {31'd0, a_err}, 32'd0);
    tick();
    reset = 1'b0;

    // load-use on rs for one cycle
    exMemRead = 1'b1; exRt = 5'd5; idRs = 5'd5;
    @(negedge clk);
    chk("lu stall", {31'd0, a_stall}, 32'd1);
    chk("lu bubble", {31'd0, a_bub}, 32'd1);
    tick(); quiet();
    @(negedge clk);
    chk("lu released", {31'd0, a_stall}, 32'd0);
    chk("lu stallCycles", {16'd0, a_sc}, 32'd1);
    tick();
    exMemRead = 1'b1; exRt = 5'd5; idRs = 5'd3; idRt = 5'd5; idUsesRt = 1'b0;
    @(negedge clk);
    chk("rt unused", {31'd0, a_stall}, 32'd0);
    tick();
    idUsesRt = 1'b1;
    @(negedge clk);
    chk("rt used", {31'd0, a_stall}, 32'd1);
    tick();
    quiet(); exMemRead = 1'b1; exRt = 5'd0; idRs = 5'd0; idRt = 5'd0; idUsesRt = 1'b1;
    @(negedge clk);
    chk("r0 stall", {31'd0, a_stall}, 32'd0);
    chk("r0 bubble", {31'd0, a_bub}, 32'd0);
    tick();

    // redirect with a simultaneous hazard
    do_reset();
    exMemRead = 1'b1; exRt = 5'd5; idRs = 5'd5; exBranchTaken = 1'b1; exBranchTarget = 32'h40;
    @(negedge clk);
    chk("redir br", {31'd0, a_br}, 32'd1);
    chk("redir addr", a_addr, 32'h40);
    chk("redir stall", {31'd0, a_stall}, 32'd0);
    chk("redir flush", {31'd0, a_flush}, 32'd1);
    tick();
    quiet(); exBranchTaken = 1'b1; exBranchTarget = 32'h80;
    @(negedge clk);
    chk("flush ignores branch", {31'd0, a_br}, 32'd0);
    chk("flush ignores addr", a_addr, 32'd0);
    chk("flush 2", {31'd0, a_flush}, 32'd1);
    chk("B second redirect", b_addr, 32'h80);
    tick(); quiet();
    @(negedge clk);
    chk("flush 3", {31'd0, a_flush}, 32'd1);
    tick();
    @(negedge clk);
    chk("flush over", {31'd0, a_flush}, 32'd0);
    chk("A redirectCount", {16'd0, a_rc}, 32'd1);
    chk("B redirectCount", {29'd0, b_rc}, 32'd2);
    tick();

    // imem wait of four cycles
    do_reset();
    imemReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("wait stall %0d", i), {31'd0, a_stall}, 32'd1);
      tick();
    end
    imemReady = 1'b1;
    @(negedge clk);
    chk("wait ready stall", {31'd0, a_stall}, 32'd0);
    tick();
    @(negedge clk);
    chk("wait stallCycles", {16'd0, a_sc}, 32'd4);
    chk("A no timeout", {31'd0, a_err}, 32'd0);
    chk("B timeout", {31'd0, b_err}, 32'd1);
    imemReady = 1'b0;
    tick(); tick();
    imemReady = 1'b1; exMemRead = 1'b1; exRt = 5'd7; idRs = 5'd7;
    @(negedge clk);
    chk("ready+hazard stall", {31'd0, a_stall}, 32'd1);
    chk("ready+hazard bubble", {31'd0, a_bub}, 32'd1);
    tick(); quiet();

    // timeout at 16 consecutive wait cycles
    do_reset();
    imemReady = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk($sformatf("timeout c%0d", i), {31'd0, a_err}, (i >= 17) ? 32'd1 : 32'd0);
      tick();
    end
    imemReady = 1'b1;
    @(negedge clk);
    chk("timeout sticky", {31'd0, a_err}, 32'd1);
    tick();
    do_reset();
    @(negedge clk);
    chk("timeout cleared", {31'd0, a_err}, 32'd0);
    tick();

    // branch during WAIT, then reset while flushing
    do_reset();
    imemReady = 1'b0;
    tick(); tick();
    exBranchTaken = 1'b1; exBranchTarget = 32'h100;
    @(negedge clk);
    chk("wait redir br", {31'd0, a_br}, 32'd1);
    chk("wait redir addr", a_addr, 32'h100);
    chk("wait redir stall", {31'd0, a_stall}, 32'd0);
    tick();
    quiet(); reset = 1'b1;
    @(negedge clk);
    chk("rst cycle flush", {31'd0, a_flush}, 32'd0);
    chk("rst cycle bubble", {31'd0, a_bub}, 32'd0);
    chk("rst cycle br", {31'd0, a_br}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post rst flush", {31'd0, a_flush}, 32'd0);
    chk("post rst stallCycles", {16'd0, a_sc}, 32'd0);
    chk("post rst redirectCount", {16'd0, a_rc}, 32'd0);
    tick();

    // counter saturation on the 3-bit instance
    do_reset();
    exMemRead = 1'b1; exRt = 5'd9; idRt = 5'd9; idUsesRt = 1'b1; idRs = 5'd1;
    repeat (10) tick();
    quiet();
    @(negedge clk);
    chk("B stallCycles sat", {29'd0, b_sc}, 32'd7);
    chk("A stallCycles 10", {16'd0, a_sc}, 32'd10);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
